// File: rtl/axi4_stream_if.sv
// AXI4-Stream interface bundle.
//
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both 1. Once tvalid is raised, the master holds tvalid and all payload
// signals (tdata/tkeep/tstrb/tlast/tuser/tdest/tid) stable until that
// transfer happens. tready may change freely and may depend on tvalid.
//
// Parameters:
//   TDATA_WIDTH - tdata width in bits (multiple of 8); tkeep/tstrb are /8
//   TDEST_WIDTH - tdest width
//   TID_WIDTH   - tid width
// Modports:
//   master - drives tvalid and payload, samples tready
//   slave  - samples tvalid and payload, drives tready
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 64,
  parameter int TDEST_WIDTH = 4,
  parameter int TID_WIDTH   = 4
);
  logic                       tvalid;
  logic                       tready;
  logic [TDATA_WIDTH-1:0]     tdata;
  logic [TDATA_WIDTH/8-1:0]   tkeep;
  logic [TDATA_WIDTH/8-1:0]   tstrb;
  logic                       tlast;
  logic                       tuser;
  logic [TDEST_WIDTH-1:0]     tdest;
  logic [TID_WIDTH-1:0]       tid;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_multiple_downsizer.sv
// AXI4-Stream width downsizer by an integer ratio.
//
// A wide input beat is captured into a buffer and replayed as RATIO narrow
// beats, lane 0 (least significant) first. On a tlast beat only the lanes up
// to the highest lane carrying any tkeep bit are emitted. tuser is forwarded
// only on lane 0 of the first wide beat of a packet; tdest/tid repeat on
// every lane. The buffer reloads in the same cycle the final lane leaves, so
// a continuous input stream yields a continuous output stream.
//
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - synchronous active-high reset
//   pkt_i     - wide input stream (slave), SLAVE_TDATA_WIDTH data
//   pkt_o     - narrow output stream (master), MASTER_TDATA_WIDTH data
//   dbg_state - current FSM state (0 = EMPTY, 1 = FULL)
module axi4_stream_multiple_downsizer #(
  parameter int SLAVE_TDATA_WIDTH  = 64,
  parameter int MASTER_TDATA_WIDTH = 32,
  parameter int TDEST_WIDTH        = 4,
  parameter int TID_WIDTH          = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o,
  output logic          dbg_state
);

  localparam int RATIO = SLAVE_TDATA_WIDTH / MASTER_TDATA_WIDTH;
  localparam int MW    = MASTER_TDATA_WIDTH;
  localparam int MK    = MASTER_TDATA_WIDTH / 8;
  localparam int POS_W = $clog2(RATIO);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [POS_W-1:0] ins_pos_q, ins_pos_d;
  logic             load;
  logic             first_q;

  // Held wide beat, viewed lane by lane.
  logic [RATIO-1:0][MW-1:0] buf_data;
  logic [RATIO-1:0][MK-1:0] buf_keep;
  logic [RATIO-1:0][MK-1:0] buf_strb;
  logic                     buf_last;
  logic                     buf_user;
  logic                     buf_first;
  logic [TDEST_WIDTH-1:0]   buf_dest;
  logic [TID_WIDTH-1:0]     buf_id;

  logic [POS_W-1:0] keep_last;
  logic [POS_W-1:0] last_lane;
  logic             final_lane;
  logic             out_valid;
  logic             in_ready;
  logic             in_hs;
  logic             out_hs;

  // Highest lane with any kept byte; lane 0 when nothing is kept.
  always_comb begin
    keep_last = '0;
    for (int n = 0; n < RATIO; n++) begin
      if (|buf_keep[n]) begin
        keep_last = POS_W'(n);
      end
    end
  end

  assign last_lane  = buf_last ? keep_last : POS_W'(RATIO - 1);
  assign final_lane = (ins_pos_q == last_lane);

  // Outputs are gated by reset so nothing transfers during the reset cycle.
  assign out_valid = (state_q == FULL) && !rst_i;
  assign in_ready  = !rst_i &&
                     ((state_q == EMPTY) || (final_lane && pkt_o.tready));
  assign in_hs     = pkt_i.tvalid && in_ready;
  assign out_hs    = out_valid && pkt_o.tready;

  always_comb begin
    state_d   = state_q;
    ins_pos_d = ins_pos_q;
    load      = 1'b0;
    if (in_hs) begin
      // Fresh beat, possibly replacing the final lane leaving this cycle.
      state_d   = FULL;
      ins_pos_d = '0;
      load      = 1'b1;
    end else if (out_hs) begin
      if (final_lane) begin
        state_d   = EMPTY;
        ins_pos_d = '0;
      end else begin
        ins_pos_d = ins_pos_q + POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      ins_pos_q <= '0;
      first_q   <= 1'b1;
      buf_data  <= '0;
      buf_keep  <= '0;
      buf_strb  <= '0;
      buf_last  <= 1'b0;
      buf_user  <= 1'b0;
      buf_first <= 1'b0;
      buf_dest  <= '0;
      buf_id    <= '0;
    end else begin
      state_q   <= state_d;
      ins_pos_q <= ins_pos_d;
      if (load) begin
        buf_data  <= pkt_i.tdata;
        buf_keep  <= pkt_i.tkeep;
        buf_strb  <= pkt_i.tstrb;
        buf_last  <= pkt_i.tlast;
        buf_user  <= pkt_i.tuser;
        buf_first <= first_q;
        buf_dest  <= pkt_i.tdest;
        buf_id    <= pkt_i.tid;
        // The beat after a tlast beat opens a new packet.
        first_q   <= pkt_i.tlast;
      end
    end
  end

  assign pkt_i.tready = in_ready;

  assign pkt_o.tvalid = out_valid;
  assign pkt_o.tdata  = buf_data[ins_pos_q];
  assign pkt_o.tkeep  = buf_keep[ins_pos_q];
  assign pkt_o.tstrb  = buf_strb[ins_pos_q];
  assign pkt_o.tlast  = !rst_i && buf_last && final_lane;
  assign pkt_o.tuser  = !rst_i && buf_user && buf_first && (ins_pos_q == '0);
  assign pkt_o.tdest  = buf_dest;
  assign pkt_o.tid    = buf_id;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi4_stream_multiple_downsizer.sv
module tb_axi4_stream_multiple_downsizer;

  localparam int LW = 32 + 4 + 4 + 1 + 1 + 4 + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(64))  s_if ();
  axi4_stream_if #(.TDATA_WIDTH(32))  m_if ();
  axi4_stream_if #(.TDATA_WIDTH(128)) s4_if ();
  axi4_stream_if #(.TDATA_WIDTH(32))  m4_if ();
  logic dbg;
  logic dbg4;

  axi4_stream_multiple_downsizer #(
    .SLAVE_TDATA_WIDTH(64), .MASTER_TDATA_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .pkt_i(s_if), .pkt_o(m_if), .dbg_state(dbg)
  );

  axi4_stream_multiple_downsizer #(
    .SLAVE_TDATA_WIDTH(128), .MASTER_TDATA_WIDTH(32)
  ) dut4 (
    .clk_i(clk), .rst_i(rst_i), .pkt_i(s4_if), .pkt_o(m4_if), .dbg_state(dbg4)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [LW-1:0] exp_q[$];
  logic m_first;
  bit   bp_en;
  logic o_rdy;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] out_word();
    return {m_if.tdata, m_if.tkeep, m_if.tstrb, m_if.tlast, m_if.tuser,
            m_if.tdest, m_if.tid};
  endfunction

  // Reference split of one accepted 64-bit beat into expected 32-bit lanes.
  task automatic model_push(input logic [63:0] d, input logic [7:0] k,
                            input logic [7:0] s, input logic l, input logic u,
                            input logic [3:0] dest, input logic [3:0] id);
    int kk;
    kk = 1;
    if (l) begin
      kk = 0;
      for (int n = 0; n < 2; n++) if (|k[n*4 +: 4]) kk = n;
    end
    for (int n = 0; n <= kk; n++) begin
      exp_q.push_back({d[n*32 +: 32], k[n*4 +: 4], s[n*4 +: 4],
                       (l && n == kk), (u && m_first && n == 0), dest, id});
    end
    m_first = l;
  endtask

  // ---------------- output backpressure driver ----------------
  always @(posedge clk) begin
    logic v;
    v = bp_en ? 1'($urandom_range(0, 1)) : o_rdy;
    #1 m_if.tready = v;
  end

  // ---------------- output monitor ----------------
  logic [LW-1:0] prev_word;
  bit stalled = 0;
  always @(negedge clk) begin
    if (rst_i) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        check("stall_valid", m_if.tvalid, 1'b1);
        check("stall_payload", out_word(), prev_word);
      end
      if (m_if.tvalid && m_if.tready) begin
        check("q_has_entry", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) check("lane", out_word(), exp_q.pop_front());
      end
      stalled   = m_if.tvalid && !m_if.tready;
      prev_word = out_word();
    end
  end

  // ---------------- input driver ----------------
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                           input logic [7:0] s, input logic l, input logic u,
                           input logic [3:0] dest, input logic [3:0] id);
    int guard;
    guard = 0;
    s_if.tdata = d; s_if.tkeep = k; s_if.tstrb = s; s_if.tlast = l;
    s_if.tuser = u; s_if.tdest = dest; s_if.tid = id; s_if.tvalid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (s_if.tready) break;
      guard++;
      if (guard > 200) begin
        check("in_accept_wait", guard, 0);
        break;
      end
    end
    if (guard <= 200) model_push(d, k, s, l, u, dest, id);
    @(posedge clk);
    #1 s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] d4;
    int g;
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tstrb = '0;
    s_if.tlast = 0; s_if.tuser = 0; s_if.tdest = '0; s_if.tid = '0;
    s4_if.tvalid = 0; s4_if.tdata = '0; s4_if.tkeep = '0; s4_if.tstrb = '0;
    s4_if.tlast = 0; s4_if.tuser = 0; s4_if.tdest = '0; s4_if.tid = '0;
    m4_if.tready = 1'b1;
    bp_en = 0; o_rdy = 1'b1; m_first = 1'b1;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", s_if.tready, 1'b0);
    check("rst_out_valid", m_if.tvalid, 1'b0);
    check("rst_out_payload", out_word(), '0);
    check("rst_state", dbg, 1'b0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", s_if.tready, 1'b1);

    // Single full beat: two lanes, tuser on lane 0, tlast on lane 1.
    send_beat(64'h1111_1111_2222_2222, 8'hFF, 8'hFF, 1'b1, 1'b1, 4'h3, 4'h5);
    check("latency_one", m_if.tvalid, 1'b1);
    drain();

    // Short tlast beats.
    send_beat(64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 8'h0F, 1'b1, 1'b0, 4'h1, 4'h2);
    drain();
    send_beat(64'h0123_4567_89AB_CDEF, 8'h00, 8'h00, 1'b1, 1'b1, 4'h7, 4'h8);
    drain();

    // Back-to-back 4-beat packet with continuous output.
    fork
      begin
        for (int b = 0; b < 4; b++)
          send_beat({32'(b * 2 + 1), 32'(b * 2)}, 8'hFF, 8'hFF, (b == 3), 1'b1,
                    4'h9, 4'hC);
      end
      begin
        g = 0;
        @(negedge clk);
        while (!m_if.tvalid && g < 20) begin
          @(negedge clk);
          g++;
        end
        for (int k = 0; k < 8; k++) begin
          check("b2b_valid", m_if.tvalid, 1'b1);
          check("b2b_in_ready", s_if.tready, 128'(k % 2));
          @(negedge clk);
        end
      end
    join
    drain();

    // Random packets under random backpressure.
    bp_en = 1;
    for (int p = 0; p < 1000; p++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        logic [7:0] k;
        k = 8'($urandom_range(0, 255));
        send_beat({$urandom, $urandom}, k, 8'($urandom_range(0, 255)),
                  (b == nb - 1), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();
    bp_en = 0;

    // Reset while lane 0 of a held beat is pending.
    o_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_beat(64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 8'hFF, 1'b0, 1'b1, 4'h4, 4'h4);
    check("held_before_rst", m_if.tvalid, 1'b1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    m_first = 1'b1;
    check("rst_mid_valid", m_if.tvalid, 1'b0);
    check("rst_mid_state", dbg, 1'b0);
    o_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_residual", m_if.tvalid, 1'b0);
    end
    @(posedge clk);
    #1;
    send_beat(64'h5555_6666_7777_8888, 8'hFF, 8'hFF, 1'b1, 1'b1, 4'hE, 4'hD);
    drain();

    // Ratio 4: tkeep 0x00F0 on a tlast beat emits lanes 0 and 1 only.
    d4 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    s4_if.tdata = d4; s4_if.tkeep = 16'h00F0; s4_if.tstrb = 16'h00F0;
    s4_if.tlast = 1'b1; s4_if.tuser = 1'b1; s4_if.tdest = 4'hA; s4_if.tid = 4'h6;
    s4_if.tvalid = 1'b1;
    @(negedge clk);
    check("r4_in_ready", s4_if.tready, 1'b1);
    @(posedge clk);
    #1 s4_if.tvalid = 1'b0;
    @(negedge clk);
    check("r4_l0_valid", m4_if.tvalid, 1'b1);
    check("r4_l0_data", m4_if.tdata, 32'h1111_1111);
    check("r4_l0_keep", m4_if.tkeep, 4'h0);
    check("r4_l0_last", m4_if.tlast, 1'b0);
    check("r4_l0_user", m4_if.tuser, 1'b1);
    check("r4_l0_dest_id", {m4_if.tdest, m4_if.tid}, 8'hA6);
    @(negedge clk);
    check("r4_l1_valid", m4_if.tvalid, 1'b1);
    check("r4_l1_data", m4_if.tdata, 32'h2222_2222);
    check("r4_l1_keep", m4_if.tkeep, 4'hF);
    check("r4_l1_last", m4_if.tlast, 1'b1);
    check("r4_l1_user", m4_if.tuser, 1'b0);
    check("r4_l1_dest_id", {m4_if.tdest, m4_if.tid}, 8'hA6);
    @(negedge clk);
    check("r4_done", m4_if.tvalid, 1'b0);

    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
